// File: rtl/aco_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aco_pkg
// Brief   : Frame and word-width constants shared by the FFT back end blocks.
// Revision: 1.0
// ============================================================================
package aco_pkg;
  localparam int ACO_I_BW     = 16;
  localparam int ACO_O_BW     = 2 * ACO_I_BW;
  localparam int ACO_FFT_LEN  = 256;
  localparam int ACO_NUM_BINS = ACO_FFT_LEN / 2 + 1;
  localparam int ACO_CNT_BW   = $clog2(ACO_FFT_LEN);
endpackage
`default_nettype wire

// File: rtl/power_spectrum_if.sv
`default_nettype none
// ============================================================================
// Module  : power_spectrum_if
// Brief   : FFT sample stream in, power stream out (no backpressure).
// Revision: 1.0
// ============================================================================
interface power_spectrum_if #(
  parameter int I_BW = 16,
  parameter int O_BW = 32
);
  logic signed [I_BW-1:0] data_re_i;
  logic signed [I_BW-1:0] data_im_i;
  logic                   valid_i;
  logic                   last_i;
  logic [O_BW-1:0]        data_o;
  logic                   valid_o;
  logic                   last_o;

  modport slave (
    input  data_re_i, data_im_i, valid_i, last_i,
    output data_o, valid_o, last_o
  );

  modport master (
    output data_re_i, data_im_i, valid_i, last_i,
    input  data_o, valid_o, last_o
  );
endinterface
`default_nettype wire

// File: rtl/power_spectrum_mag_sq.sv
`default_nettype none
// ============================================================================
// Module  : complex_mag_sq
// Brief   : Two-stage re^2 + im^2 pipeline carrying a valid bit and a tag.
// Revision: 1.0
// ============================================================================
module complex_mag_sq #(
  parameter int I_BW   = 16,
  parameter int O_BW   = 2 * I_BW,
  parameter int TAG_BW = 1
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_i,
  input  wire logic                   flush_i,
  input  wire logic                   valid_i,
  input  wire logic [TAG_BW-1:0]      tag_i,
  input  wire logic signed [I_BW-1:0] re_i,
  input  wire logic signed [I_BW-1:0] im_i,
  output logic                        valid_o,
  output logic [TAG_BW-1:0]           tag_o,
  output logic [O_BW-1:0]             data_o
);
  logic signed [O_BW-1:0] re_sq_w;
  logic signed [O_BW-1:0] im_sq_w;
  logic [O_BW-1:0]        re_sq_q;
  logic [O_BW-1:0]        im_sq_q;
  logic                   v1_q;
  logic [TAG_BW-1:0]      tag1_q;
  logic                   v2_q;
  logic [TAG_BW-1:0]      tag2_q;
  logic [O_BW-1:0]        data_q;
  logic                   adv_w;

  // Both operands are signed, so they are sign-extended to O_BW before multiplying.
  assign re_sq_w = re_i * re_i;
  assign im_sq_w = im_i * im_i;
  assign adv_w   = v1_q & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      re_sq_q <= '0;
      im_sq_q <= '0;
      v1_q    <= 1'b0;
      tag1_q  <= '0;
      v2_q    <= 1'b0;
      tag2_q  <= '0;
      data_q  <= '0;
    end else begin
      v1_q <= valid_i & ~flush_i;
      if (valid_i) begin
        re_sq_q <= $unsigned(re_sq_w);
        im_sq_q <= $unsigned(im_sq_w);
        tag1_q  <= tag_i;
      end
      v2_q   <= adv_w;
      tag2_q <= adv_w ? tag1_q : '0;
      if (adv_w) begin
        data_q <= re_sq_q + im_sq_q;
      end
    end
  end

  assign valid_o = v2_q;
  assign tag_o   = tag2_q;
  assign data_o  = data_q;
endmodule
`default_nettype wire

// File: rtl/power_spectrum.sv
`default_nettype none
// ============================================================================
// Module  : power_spectrum
// Brief   : |X[k]|^2 for the non-redundant FFT bins, with framing checks.
// Revision: 1.0
// ============================================================================
module power_spectrum
  import aco_pkg::*;
#(
  parameter int I_BW     = ACO_I_BW,
  parameter int O_BW     = ACO_O_BW,
  parameter int FFT_LEN  = ACO_FFT_LEN,
  parameter int NUM_BINS = ACO_NUM_BINS,
  parameter int CNT_BW   = ACO_CNT_BW
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  input  wire logic         en_i,
  power_spectrum_if.slave   s_if,
  output logic              err_o
);
  localparam logic [CNT_BW-1:0] LAST_BIN = CNT_BW'(NUM_BINS - 1);
  localparam logic [CNT_BW-1:0] END_CNT  = CNT_BW'(FFT_LEN - 1);

  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              accept_w;
  logic              at_end_w;
  logic              keep_w;
  logic              last_tag_w;

  assign accept_w   = en_i & s_if.valid_i;
  assign at_end_w   = (cnt_q == END_CNT);
  assign keep_w     = (cnt_q <= LAST_BIN);
  assign last_tag_w = keep_w & ((cnt_q == LAST_BIN) | s_if.last_i);

  // A frame ends either on last_i or on the counter reaching FFT_LEN-1;
  // disagreement between the two is a short or long frame.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (accept_w) begin
      if (s_if.last_i || at_end_w) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (s_if.last_i != at_end_w) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  complex_mag_sq #(
    .I_BW   (I_BW),
    .O_BW   (O_BW),
    .TAG_BW (1)
  ) u_mag_sq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (~en_i),
    .valid_i (accept_w & keep_w),
    .tag_i   (last_tag_w),
    .re_i    (s_if.data_re_i),
    .im_i    (s_if.data_im_i),
    .valid_o (s_if.valid_o),
    .tag_o   (s_if.last_o),
    .data_o  (s_if.data_o)
  );

  assign err_o = err_q;
endmodule
`default_nettype wire
